// File: rtl/octa16_pkg.sv
// rtl/octa16_pkg.sv - shared register-file constants and write-back source encoding
package octa16_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int NREGS      = 8;
    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-way round-robin grant between ALU and load write-back
module wb_rr_arbiter
    import octa16_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic grant_alu,
    output logic grant_mem
);
    src_e rr_last;
    logic conflict;

    assign conflict  = alu_valid & mem_valid;
    // On a conflict the source that did not win last time gets the port.
    assign grant_alu = alu_valid & (~mem_valid | (rr_last == SRC_MEM));
    assign grant_mem = mem_valid & ~grant_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= SRC_MEM;
        end else if (conflict) begin
            rr_last <= grant_alu ? SRC_ALU : SRC_MEM;
        end
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-back port arbitration and RAW/WAW hazard scoreboard
module regfile_wb_ctrl
    import octa16_pkg::*;
#(
    parameter int DATA_WIDTH = octa16_pkg::DATA_WIDTH,
    parameter int NREGS      = octa16_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_wr,
    output logic                  issue_stall,
    input  logic                  flush,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);
    logic                  accept;
    logic                  issue_set;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_next;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .grant_alu (alu_ready),
        .grant_mem (mem_ready)
    );

    assign accept   = alu_ready | mem_ready;
    assign win_rd   = mem_ready ? mem_rd   : alu_rd;
    assign win_data = mem_ready ? mem_data : alu_data;

    // pending[0] is forced low, so x0 never produces a hazard.
    assign issue_stall = issue_valid & (pending[issue_rs1] | pending[issue_rs2] |
                                        (issue_wr & pending[issue_rd]));
    assign issue_set   = issue_valid & issue_wr & ~issue_stall & (issue_rd != '0);
    assign busy        = |pending;

    // Set is applied after clear so a forced same-register collision leaves it pending.
    always_comb begin
        pending_next = pending;
        if (wr_en) begin
            pending_next[wr_addr] = 1'b0;
        end
        if (issue_set) begin
            pending_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            pending_next = '0;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            pending <= pending_next;
            wr_en   <= accept & (win_rd != '0);
            if (accept) begin
                wr_addr <= win_rd;
                wr_data <= win_data;
            end
        end
    end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller and hazard scoreboard for the 8-entry register file (reg_ff).
- Arbitrates two write-back sources onto the register file's single write port: ALU and memory/load unit.
- Tracks in-flight destination registers so the issue stage stalls on RAW and WAW hazards.
- Sits between the execute/memory stages and reg_ff; drives reg_ff's wrEn, rd and dIn.

Parameters:
- DATA_WIDTH, 8, width of write-back data; must match reg_ff DATA_WIDTH.
- NREGS, 8, number of architectural registers; fixed at 8 (3-bit addresses).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_rd  in  3  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load write-back request
- mem_rd  in  3  load destination register
- mem_data  in  DATA_WIDTH  load data
- mem_ready  out  1  load request accepted this cycle
- issue_valid  in  1  issue stage presents an instruction
- issue_rs1  in  3  source register 1
- issue_rs2  in  3  source register 2
- issue_rd  in  3  destination register
- issue_wr  in  1  instruction writes issue_rd
- issue_stall  out  1  hazard; instruction must hold
- flush  in  1  synchronous scoreboard clear (pipeline flush)
- wr_en  out  1  to reg_ff wrEn
- wr_addr  out  3  to reg_ff rd
- wr_data  out  DATA_WIDTH  to reg_ff dIn
- busy  out  1  any register pending

Behaviour:
- Reset (async, immediate): wr_en=0, wr_addr=0, wr_data=0, pending[7:0]=0, rr_last=MEM (ALU wins the first conflict), busy=0.
- Reset semantics: any request in progress is dropped; no write is emitted after reset deasserts until a new handshake.
- Arbitration (combinational grant):
  - Only one valid: that source is granted.
  - Both valid: the source not equal to rr_last is granted, and rr_last updates to the winner.
  - rr_last updates only on conflict cycles.
  - alu_ready = grant_alu; mem_ready = grant_mem; never both high.
  - A source holds valid/rd/data stable until its ready is seen.
- Write port (registered, 1-cycle latency):
  - Accept edge: wr_addr and wr_data load the winner's rd and data. wr_en=1 if winner rd!=0, else 0.
  - Writes to x0 complete the handshake silently.
  - wr_en is held 1 only for the cycle after acceptance; back-to-back accepts give consecutive wr_en pulses.
  - With no accept, wr_en=0 and wr_addr/wr_data hold their last values.
- Scoreboard, pending[0] always 0:
  - set: issue_valid & issue_wr & !issue_stall & issue_rd!=0 sets pending[issue_rd] at the edge.
  - clear: wr_en=1 clears pending[wr_addr] at the same edge reg_ff captures the data.
  - set and clear of the same register in one cycle cannot occur legally, because WAW stalls. If forced, set wins.
  - clear of a non-pending register is a no-op.
- issue_stall = issue_valid & ( pending[rs1] | pending[rs2] | (issue_wr & pending[rd]) ). Register 0 is never a hazard.
  - Stall uses registered pending only; there is no same-cycle bypass.
  - An instruction reading a register whose wr_en pulse is in the current cycle stalls exactly one more cycle.
- flush:
  - Clears all pending bits at the next edge and suppresses that cycle's scoreboard set.
  - Does not cancel an already-registered wr_en pulse, nor a handshake in the same cycle. Those complete normally.
- busy = |pending.

Decomposition:
- Shared package (octa16_pkg):
  - REG_ADDR_W=3, NREGS=8.
  - source enum SRC_ALU=0, SRC_MEM=1.
  - DATA_WIDTH default.
- One natural sub-module: wb_rr_arbiter. It is the 2-way round-robin grant with the rr_last flop.
- Scoreboard and write register stay in the top.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert rst while alu_valid=1 and pending=8'b0000_0110.
  - Required: wr_en=0, pending=0 and busy=0 immediately, without a clock edge.
  - Required: after release, the first conflict grants ALU.
- Single ALU write:
  - Stimulus: alu_valid, alu_rd=3, alu_data=8'hA5.
  - Required: alu_ready=1 that cycle.
  - Required: next cycle wr_en=1, wr_addr=3, wr_data=8'hA5; following cycle wr_en=0.
- Conflict sequence:
  - Stimulus: both sources valid for 4 cycles (rd=1 and rd=2), with each handshake re-presenting.
  - Required: grants alternate ALU, MEM, ALU, MEM.
  - Required: wr_addr sequence 1,2,1,2 with a continuous wr_en.
- RAW hazard:
  - Stimulus: issue rd=5 (issue_wr=1, no stall), then issue rs1=5.
  - Required: issue_stall=1 until the mem write to 5 produces its wr_en cycle.
  - Required: stall is still 1 during that cycle and drops the cycle after; busy then falls.
- x0 handling:
  - Stimulus: mem_rd=0, mem_data=8'hFF.
  - Required: mem_ready=1, next-cycle wr_en=0, pending unchanged.
  - Stimulus: issue rs1=0, rs2=0, rd=0.
  - Required: issue_stall=0 regardless of pending.
- Flush:
  - Stimulus: pending=8'b1010_1010, then flush=1 with issue rd=4 valid.
  - Required: pending=0 next cycle, bit 4 is not set, busy=0.
